// File: rtl/cond_pkg.sv
// Shared types and constants for the pipelined ARM condition-evaluation unit.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
    MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
    HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
    GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
  } cond_e;

  localparam int FLAG_N = 4;
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Q = 0;

  localparam logic [3:0] COND_BUBBLE = 4'hE;

  typedef struct packed {
    logic       valid;
    logic [3:0] cond;
    logic [1:0] flagw;
    logic       pcs;
    logic       regw;
    logic       memw;
    logic       nowrite;
    logic       qset;
  } ectl_t;

  function automatic ectl_t ectl_bubble();
    ectl_t b;
    b         = '0;
    b.cond    = COND_BUBBLE;
    return b;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-code check against {N,Z,C,V}.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] nzcv_i,
  input  logic       nv_exec_i,
  output logic       pass_o
);

  logic n, z, c, v;

  assign n = nzcv_i[3];
  assign z = nzcv_i[2];
  assign c = nzcv_i[1];
  assign v = nzcv_i[0];

  always_comb begin
    pass_o = 1'b0;
    case (cond_e'(cond_i))
      EQ: pass_o = z;
      NE: pass_o = ~z;
      CS: pass_o = c;
      CC: pass_o = ~c;
      MI: pass_o = n;
      PL: pass_o = ~n;
      VS: pass_o = v;
      VC: pass_o = ~v;
      HI: pass_o = c & ~z;
      LS: pass_o = ~c | z;
      GE: pass_o = (n == v);
      LT: pass_o = (n != v);
      GT: pass_o = ~z & (n == v);
      LE: pass_o = z | (n != v);
      AL: pass_o = 1'b1;
      NV: pass_o = nv_exec_i;
    endcase
  end

endmodule

// File: rtl/condlogic_pipe.sv
// Execute-stage conditional logic: E register, flag register with restore,
// condition-gated write enables and saturating executed/annulled counters.
module condlogic_pipe
  import cond_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int HAS_Q   = 1,
  parameter int NV_EXEC = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       CondD,
  input  logic [1:0]       FlagWD,
  input  logic             PCSD,
  input  logic             RegWD,
  input  logic             MemWD,
  input  logic             NoWriteD,
  input  logic             QSetD,
  input  logic             ValidD,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic [3:0]       ALUFlagsE,
  input  logic             RestoreEn,
  input  logic [4:0]       RestoreFlags,
  input  logic             CntClr,
  output logic             PCSrcE,
  output logic             RegWriteE,
  output logic             MemWriteE,
  output logic             CondExE,
  output logic [4:0]       Flags,
  output logic             CarryE,
  output logic [CNT_W-1:0] ExecCnt,
  output logic [CNT_W-1:0] AnnulCnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction

  ectl_t            e_q, e_d, d_in;
  logic [4:0]       flags_q, flags_d;
  logic [CNT_W-1:0] exec_q, exec_d, annul_q, annul_d;
  logic             pass, commit;

  always_comb begin
    d_in         = '0;
    d_in.valid   = ValidD;
    d_in.cond    = CondD;
    d_in.flagw   = FlagWD;
    d_in.pcs     = PCSD;
    d_in.regw    = RegWD;
    d_in.memw    = MemWD;
    d_in.nowrite = NoWriteD;
    d_in.qset    = (HAS_Q != 0) ? QSetD : 1'b0;
  end

  // Decode -> Execute boundary
  always_comb begin
    e_d = e_q;
    if (FlushE)       e_d = ectl_bubble();
    else if (!StallE) e_d = d_in;
  end

  always_ff @(posedge clk) begin
    if (reset) e_q <= ectl_bubble();
    else       e_q <= e_d;
  end

  cond_eval u_cond_eval (
    .cond_i    (e_q.cond),
    .nzcv_i    (flags_q[FLAG_N:FLAG_V]),
    .nv_exec_i (NV_EXEC != 0),
    .pass_o    (pass)
  );

  assign CondExE   = e_q.valid & pass;
  assign PCSrcE    = e_q.pcs & CondExE;
  assign MemWriteE = e_q.memw & CondExE;
  assign RegWriteE = e_q.regw & CondExE & ~e_q.nowrite;
  // A stalled instruction re-evaluates next cycle, so it must not disturb its own flags.
  assign commit    = CondExE & ~StallE;

  always_comb begin
    flags_d = flags_q;
    if (RestoreEn) begin
      flags_d = RestoreFlags;
      if (HAS_Q == 0) flags_d[FLAG_Q] = 1'b0;
    end else if (commit) begin
      if (e_q.flagw[1]) begin
        flags_d[FLAG_N] = ALUFlagsE[3];
        flags_d[FLAG_Z] = ALUFlagsE[2];
      end
      if (e_q.flagw[0]) begin
        flags_d[FLAG_C] = ALUFlagsE[1];
        flags_d[FLAG_V] = ALUFlagsE[0];
      end
      if (e_q.qset) flags_d[FLAG_Q] = 1'b1;
    end
  end

  // Execute -> architectural state boundary
  always_comb begin
    exec_d  = exec_q;
    annul_d = annul_q;
    if (CntClr) begin
      exec_d  = '0;
      annul_d = '0;
    end else if (e_q.valid && !StallE) begin
      if (pass) exec_d  = sat_inc(exec_q);
      else      annul_d = sat_inc(annul_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= '0;
      exec_q  <= '0;
      annul_q <= '0;
    end else begin
      flags_q <= flags_d;
      exec_q  <= exec_d;
      annul_q <= annul_d;
    end
  end

  assign Flags    = flags_q;
  assign CarryE   = flags_q[FLAG_C];
  assign ExecCnt  = exec_q;
  assign AnnulCnt = annul_q;

endmodule

// File: tb/tb_condlogic_pipe.sv
// Directed bench for condlogic_pipe: a default instance plus a CNT_W=2,
// HAS_Q=0, NV_EXEC=1 instance driven by the same stimulus.
module tb_condlogic_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] CondD;
  logic [1:0] FlagWD;
  logic       PCSD, RegWD, MemWD, NoWriteD, QSetD, ValidD;
  logic       StallE, FlushE;
  logic [3:0] ALUFlagsE;
  logic       RestoreEn;
  logic [4:0] RestoreFlags;
  logic       CntClr;

  logic        PCSrcE, RegWriteE, MemWriteE, CondExE, CarryE;
  logic [4:0]  Flags;
  logic [15:0] ExecCnt, AnnulCnt;

  logic       PCSrcE2, RegWriteE2, MemWriteE2, CondExE2, CarryE2;
  logic [4:0] Flags2;
  logic [1:0] ExecCnt2, AnnulCnt2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  condlogic_pipe #(.CNT_W(16), .HAS_Q(1), .NV_EXEC(0)) dut (
    .clk(clk), .reset(reset), .CondD(CondD), .FlagWD(FlagWD), .PCSD(PCSD),
    .RegWD(RegWD), .MemWD(MemWD), .NoWriteD(NoWriteD), .QSetD(QSetD),
    .ValidD(ValidD), .StallE(StallE), .FlushE(FlushE), .ALUFlagsE(ALUFlagsE),
    .RestoreEn(RestoreEn), .RestoreFlags(RestoreFlags), .CntClr(CntClr),
    .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .CondExE(CondExE), .Flags(Flags), .CarryE(CarryE),
    .ExecCnt(ExecCnt), .AnnulCnt(AnnulCnt)
  );

  condlogic_pipe #(.CNT_W(2), .HAS_Q(0), .NV_EXEC(1)) dut2 (
    .clk(clk), .reset(reset), .CondD(CondD), .FlagWD(FlagWD), .PCSD(PCSD),
    .RegWD(RegWD), .MemWD(MemWD), .NoWriteD(NoWriteD), .QSetD(QSetD),
    .ValidD(ValidD), .StallE(StallE), .FlushE(FlushE), .ALUFlagsE(ALUFlagsE),
    .RestoreEn(RestoreEn), .RestoreFlags(RestoreFlags), .CntClr(CntClr),
    .PCSrcE(PCSrcE2), .RegWriteE(RegWriteE2), .MemWriteE(MemWriteE2),
    .CondExE(CondExE2), .Flags(Flags2), .CarryE(CarryE2),
    .ExecCnt(ExecCnt2), .AnnulCnt(AnnulCnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_d(input logic v, input logic [3:0] c, input logic [1:0] fw,
                         input logic rw, input logic mw, input logic pcs,
                         input logic nw, input logic qs);
    ValidD = v; CondD = c; FlagWD = fw; RegWD = rw; MemWD = mw;
    PCSD = pcs; NoWriteD = nw; QSetD = qs;
  endtask

  initial begin
    reset = 1'b1; StallE = 0; FlushE = 0; ALUFlagsE = 0;
    RestoreEn = 0; RestoreFlags = 0; CntClr = 0;
    drive_d(1, 4'h0, 2'b11, 1, 1, 1, 0, 1);
    step(); step();
    reset = 1'b0;
    drive_d(0, 4'hE, 0, 0, 0, 0, 0, 0);
    chk("rst_flags", Flags, 0);
    chk("rst_exec", ExecCnt, 0);
    chk("rst_annul", AnnulCnt, 0);
    chk("rst_condex", CondExE, 0);
    chk("rst_wr", {PCSrcE, RegWriteE, MemWriteE, CarryE}, 0);

    // SUBS setting Z, followed by EQ
    drive_d(1, 4'hE, 2'b11, 1, 0, 0, 0, 0);
    step();
    ALUFlagsE = 4'b0100;
    chk("subs_condex", CondExE, 1);
    drive_d(1, 4'h0, 2'b00, 1, 0, 0, 0, 0);
    step();
    chk("eq_flags", Flags, 5'b01000);
    chk("eq_condex", CondExE, 1);
    chk("eq_regwrite", RegWriteE, 1);
    drive_d(0, 4'hE, 0, 0, 0, 0, 0, 0);
    step();
    chk("eq_exec", ExecCnt, 2);

    // Clear Z, then annulled EQ store/branch that also tries to write flags
    drive_d(1, 4'hE, 2'b11, 0, 0, 0, 0, 0);
    step();
    ALUFlagsE = 4'b0000;
    drive_d(1, 4'h0, 2'b11, 0, 1, 1, 0, 0);
    step();
    chk("clrz_flags", Flags, 0);
    ALUFlagsE = 4'b1111;
    chk("ann_memw", MemWriteE, 0);
    chk("ann_pcsrc", PCSrcE, 0);
    chk("ann_condex", CondExE, 0);
    drive_d(0, 4'hE, 0, 0, 0, 0, 0, 0);
    step();
    chk("ann_cnt", AnnulCnt, 1);
    chk("ann_flags", Flags, 0);
    chk("ann_exec", ExecCnt, 3);

    // Set Z, then a flag-setting EQ stalled for 3 cycles
    drive_d(1, 4'hE, 2'b10, 0, 0, 0, 0, 0);
    step();
    ALUFlagsE = 4'b0100;
    drive_d(1, 4'h0, 2'b11, 1, 0, 0, 0, 0);
    step();
    chk("setz_flags", Flags, 5'b01000);
    ALUFlagsE = 4'b0000;
    StallE = 1;
    drive_d(0, 4'hE, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_flags", Flags, 5'b01000);
      chk("stall_exec", ExecCnt, 4);
      chk("stall_condex", CondExE, 1);
    end
    StallE = 0;
    step();
    chk("rel_flags", Flags, 0);
    chk("rel_exec", ExecCnt, 5);
    chk("rel_annul", AnnulCnt, 1);
    chk("sat_exec2", ExecCnt2, 3);
    chk("annul2", AnnulCnt2, 1);

    // Restore overrides a committing ALU write
    drive_d(1, 4'hE, 2'b11, 0, 0, 0, 0, 0);
    step();
    ALUFlagsE = 4'b1111;
    RestoreEn = 1; RestoreFlags = 5'b10011;
    drive_d(0, 4'hE, 0, 0, 0, 0, 0, 0);
    step();
    chk("restore_flags", Flags, 5'b10011);
    chk("restore_flags2", Flags2, 5'b10010);
    chk("restore_exec", ExecCnt, 6);

    // Sticky Q
    RestoreFlags = 5'b00000;
    drive_d(1, 4'hE, 2'b00, 0, 0, 0, 0, 1);
    step();
    RestoreEn = 0;
    chk("q_clear", Flags, 0);
    drive_d(1, 4'hE, 2'b11, 0, 0, 0, 0, 0);
    step();
    chk("q_set", Flags, 5'b00001);
    chk("q_set2", Flags2, 0);
    ALUFlagsE = 4'b1010;
    drive_d(0, 4'hE, 0, 0, 0, 0, 0, 0);
    step();
    chk("q_sticky", Flags, 5'b10101);
    chk("q_sticky2", Flags2, 5'b10100);
    chk("carry", CarryE, 1);
    chk("q_exec", ExecCnt, 8);
    RestoreEn = 1; RestoreFlags = 5'b01100;
    step();
    RestoreEn = 0;
    chk("q_restore0", Flags, 5'b01100);

    // NV and NoWrite
    drive_d(1, 4'hF, 2'b00, 1, 0, 0, 0, 0);
    step();
    chk("nv_condex", CondExE, 0);
    chk("nv_condex2", CondExE2, 1);
    chk("nv_regw2", RegWriteE2, 1);
    drive_d(1, 4'hE, 2'b00, 1, 0, 0, 1, 0);
    step();
    chk("nv_annul", AnnulCnt, 2);
    chk("nowr_condex", CondExE, 1);
    chk("nowr_regw", RegWriteE, 0);

    // Condition scan with Z=1, C=1, N=V=0
    drive_d(1, 4'h8, 0, 0, 0, 0, 0, 0);
    step();
    chk("hi", CondExE, 0);
    CondD = 4'h9; step(); chk("ls", CondExE, 1);
    CondD = 4'hA; step(); chk("ge", CondExE, 1);
    CondD = 4'hC; step(); chk("gt", CondExE, 0);
    CondD = 4'hB; step(); chk("lt", CondExE, 0);
    drive_d(0, 4'hE, 0, 0, 0, 0, 0, 0);
    step();
    chk("scan_exec", ExecCnt, 11);
    chk("scan_annul", AnnulCnt, 5);
    chk("scan_flags", Flags, 5'b01100);

    // CntClr beats a passing instruction, then saturation
    drive_d(1, 4'hE, 0, 0, 0, 0, 0, 0);
    step();
    CntClr = 1;
    step();
    CntClr = 0;
    chk("clr_exec", ExecCnt, 0);
    chk("clr_annul", AnnulCnt, 0);
    chk("clr_exec2", ExecCnt2, 0);
    for (int i = 0; i < 5; i++) step();
    drive_d(0, 4'hE, 0, 0, 0, 0, 0, 0);
    step();
    chk("cnt5_exec", ExecCnt, 6);
    chk("cnt5_exec2", ExecCnt2, 3);

    // Flush and stall together
    drive_d(1, 4'hE, 2'b11, 0, 0, 0, 0, 0);
    step();
    ALUFlagsE = 4'b1111;
    FlushE = 1; StallE = 1;
    drive_d(0, 4'hE, 0, 0, 0, 0, 0, 0);
    step();
    FlushE = 0; StallE = 0;
    chk("fs_condex", CondExE, 0);
    chk("fs_flags", Flags, 5'b01100);
    chk("fs_exec", ExecCnt, 6);
    step();
    chk("fs_exec_after", ExecCnt, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
